cc_displaytimer_counter: RTL and testbench

//  Free-running cycle counter feeding CC_DISPLAYTIMER_COMPARATOR, plus a per-life seconds countdown.

---
 rtl/cc_displaytimer_pkg.sv | 21 ++
 rtl/cc_displaytimer_counter_if.sv | 38 +++
 rtl/cc_displaytimer_seconds_down.sv | 41 ++++
 rtl/cc_displaytimer_counter.sv | 130 +++++++++++++
 tb/tb_cc_displaytimer_counter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cc_displaytimer_pkg.sv
// ---------------------------------------------------------------------------
// cc_displaytimer_pkg
//   Definitions shared by the display-timer counter and its comparator:
//   - state_t                   : 2-bit counter FSM encoding
//   - DISPLAYTIMER_DATAWIDTH_DEF: default width of the cycle-count bus
//   - DISPLAYTIMER_TERMINAL_2S  : terminal count for a 2 s tick at 50 MHz
//                                 (the count runs 0..terminal, terminal+1 cycles)
// ---------------------------------------------------------------------------
package cc_displaytimer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DISPLAYTIMER_DATAWIDTH_DEF = 27;
  localparam int DISPLAYTIMER_TERMINAL_2S   = 99_999_999;

endpackage

// File: rtl/cc_displaytimer_counter_if.sv
// ---------------------------------------------------------------------------
// cc_displaytimer_counter_if
//   Control and data signals of cc_displaytimer_counter. Signal names are
//   the counter's port names without the CC_DISPLAYTIMER_COUNTER_ prefix.
//   slave  : the counter (takes start/pause/T0, drives data and status)
//   master : the surroundings (game FSM + comparator)
//     start_InLow     low = (re)load and run
//     pause_InLow     low = freeze counting
//     T0_InLow        comparator match, low when data_OutBUS == terminal
//     data_OutBUS     cycle count towards the comparator
//     seconds_OutBUS  remaining seconds
//     tick_OutHigh    one-cycle pulse per wrap
//     timeout_OutHigh high once the seconds are used up
//     running_OutHigh high while counting
// ---------------------------------------------------------------------------
interface cc_displaytimer_counter_if #(
  parameter int DW = 27,
  parameter int SW = 7
);
  logic          start_InLow;
  logic          pause_InLow;
  logic          T0_InLow;
  logic [DW-1:0] data_OutBUS;
  logic [SW-1:0] seconds_OutBUS;
  logic          tick_OutHigh;
  logic          timeout_OutHigh;
  logic          running_OutHigh;

  modport slave (
    input  start_InLow, pause_InLow, T0_InLow,
    output data_OutBUS, seconds_OutBUS, tick_OutHigh, timeout_OutHigh, running_OutHigh
  );

  modport master (
    output start_InLow, pause_InLow, T0_InLow,
    input  data_OutBUS, seconds_OutBUS, tick_OutHigh, timeout_OutHigh, running_OutHigh
  );
endinterface

// File: rtl/cc_displaytimer_seconds_down.sv
// ---------------------------------------------------------------------------
// cc_displaytimer_seconds_down
//   Loadable SW-bit down counter with zero flag. Load has priority over
//   decrement; a decrement at zero is ignored so the count never underflows.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset (count <= RESET_VALUE)
//     i_load    load i_init on this edge
//     i_dec     decrement on this edge
//     i_init    value to load
//     o_count   registered count
//     o_zero    high while the count is zero
// ---------------------------------------------------------------------------
module cc_displaytimer_seconds_down #(
  parameter int SW          = 7,
  parameter int RESET_VALUE = 60
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_dec,
  input  logic [SW-1:0] i_init,
  output logic [SW-1:0] o_count,
  output logic          o_zero
);

  logic [SW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= SW'(RESET_VALUE);
    end else if (i_load) begin
      r_count <= i_init;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - SW'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/cc_displaytimer_counter.sv
// ---------------------------------------------------------------------------
// cc_displaytimer_counter
//   Free-running cycle counter feeding the display-timer comparator, plus a
//   per-life seconds countdown. The count wraps to 0 when the comparator's
//   active-low match (T0) is seen in RUN; each wrap is a tick and costs one
//   second. Running out of seconds ends in DONE (timeout) until restarted.
//   Edge priority: start > T0 wrap > pause.
//   Ports:
//     CC_DISPLAYTIMER_COUNTER_CLOCK_50      system clock
//     CC_DISPLAYTIMER_COUNTER_RESET_InHigh  asynchronous reset, active-high
//     bus (slave)                           start/pause/T0 in;
//                                           data/seconds/tick/timeout/running out
// ---------------------------------------------------------------------------
module cc_displaytimer_counter
  import cc_displaytimer_pkg::*;
#(
  parameter int DISPLAYTIMER_DATAWIDTH = 27,
  parameter int SECONDS_WIDTH          = 7,
  parameter int SECONDS_INIT           = 60
) (
  input  logic                      CC_DISPLAYTIMER_COUNTER_CLOCK_50,
  input  logic                      CC_DISPLAYTIMER_COUNTER_RESET_InHigh,
  cc_displaytimer_counter_if.slave  bus
);

  localparam int                 DW          = DISPLAYTIMER_DATAWIDTH;
  localparam int                 SW          = SECONDS_WIDTH;
  localparam logic [SW-1:0]      LP_SEC_INIT = SW'(SECONDS_INIT);
  // With no seconds to spend, a start lands directly in DONE.
  localparam bit                 LP_INIT_ZERO = (SECONDS_INIT == 0);

  state_t        r_state;
  logic [DW-1:0] r_data;
  logic          r_tick;
  logic          r_timeout;
  logic          r_running;

  logic          w_start;
  logic          w_pause;
  logic          w_wrap;
  logic          w_sec_dec;
  logic          w_sec_zero;
  logic          w_sec_last;
  logic [SW-1:0] w_seconds;

  assign w_start    = ~bus.start_InLow;
  assign w_pause    = ~bus.pause_InLow;
  assign w_wrap     = (r_state == ST_RUN) && ~bus.T0_InLow;
  assign w_sec_dec  = ~w_start && w_wrap;
  assign w_sec_last = (w_seconds == SW'(1));

  cc_displaytimer_seconds_down #(
    .SW          (SW),
    .RESET_VALUE (SECONDS_INIT)
  ) u_seconds (
    .clk     (CC_DISPLAYTIMER_COUNTER_CLOCK_50),
    .rst     (CC_DISPLAYTIMER_COUNTER_RESET_InHigh),
    .i_load  (w_start),
    .i_dec   (w_sec_dec),
    .i_init  (LP_SEC_INIT),
    .o_count (w_seconds),
    .o_zero  (w_sec_zero)
  );

  always_ff @(posedge CC_DISPLAYTIMER_COUNTER_CLOCK_50 or posedge CC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
    if (CC_DISPLAYTIMER_COUNTER_RESET_InHigh) begin
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_tick    <= 1'b0;
      r_timeout <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_start) begin
        r_data <= '0;
        if (LP_INIT_ZERO) begin
          r_state   <= ST_DONE;
          r_timeout <= 1'b1;
          r_running <= 1'b0;
        end else begin
          r_state   <= ST_RUN;
          r_timeout <= 1'b0;
          r_running <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_wrap) begin
              // Wrap and spend a second before honouring a coincident pause.
              r_data <= '0;
              r_tick <= 1'b1;
              if (w_sec_last || w_sec_zero) begin
                r_state   <= ST_DONE;
                r_timeout <= 1'b1;
                r_running <= 1'b0;
              end else if (w_pause) begin
                r_state   <= ST_PAUSE;
                r_running <= 1'b0;
              end
            end else if (w_pause) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else begin
              // All-ones rolls over naturally without a tick: only T0 ticks.
              r_data <= r_data + DW'(1);
            end
          end
          ST_PAUSE: begin
            if (!w_pause) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_DONE: begin
            r_data <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.data_OutBUS     = r_data;
  assign bus.seconds_OutBUS  = w_seconds;
  assign bus.tick_OutHigh    = r_tick;
  assign bus.timeout_OutHigh = r_timeout;
  assign bus.running_OutHigh = r_running;

endmodule

// File: tb/tb_cc_displaytimer_counter.sv
// ---------------------------------------------------------------------------
// tb_cc_displaytimer_counter
//   dut_a : SECONDS_INIT=3, stub comparator (T0 low when data == 9)
//   dut_z : SECONDS_INIT=0, same stub
//   dut_r : SECONDS_INIT=60, real 2 s terminal comparator
//   A directed vector table, hand-written corner sequences and a randomized
//   run against a behavioural model of dut_a.
// ---------------------------------------------------------------------------
module tb_cc_displaytimer_counter;
  import cc_displaytimer_pkg::*;

  localparam int DW     = 27;
  localparam int SW     = 7;
  localparam int M_INIT = 3;
  localparam int M_TERM = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cc_displaytimer_counter_if #(.DW(DW), .SW(SW)) bus_a ();
  cc_displaytimer_counter_if #(.DW(DW), .SW(SW)) bus_z ();
  cc_displaytimer_counter_if #(.DW(DW), .SW(SW)) bus_r ();

  assign bus_a.T0_InLow = (bus_a.data_OutBUS != DW'(M_TERM));
  assign bus_z.T0_InLow = (bus_z.data_OutBUS != DW'(M_TERM));
  assign bus_r.T0_InLow = (bus_r.data_OutBUS != DW'(DISPLAYTIMER_TERMINAL_2S));

  cc_displaytimer_counter #(.DISPLAYTIMER_DATAWIDTH(DW), .SECONDS_WIDTH(SW), .SECONDS_INIT(3)) dut_a (
    .CC_DISPLAYTIMER_COUNTER_CLOCK_50     (clk),
    .CC_DISPLAYTIMER_COUNTER_RESET_InHigh (rst),
    .bus                                  (bus_a.slave)
  );
  cc_displaytimer_counter #(.DISPLAYTIMER_DATAWIDTH(DW), .SECONDS_WIDTH(SW), .SECONDS_INIT(0)) dut_z (
    .CC_DISPLAYTIMER_COUNTER_CLOCK_50     (clk),
    .CC_DISPLAYTIMER_COUNTER_RESET_InHigh (rst),
    .bus                                  (bus_z.slave)
  );
  cc_displaytimer_counter #(.DISPLAYTIMER_DATAWIDTH(DW), .SECONDS_WIDTH(SW), .SECONDS_INIT(60)) dut_r (
    .CC_DISPLAYTIMER_COUNTER_CLOCK_50     (clk),
    .CC_DISPLAYTIMER_COUNTER_RESET_InHigh (rst),
    .bus                                  (bus_r.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit start_n;
    bit pause_n;
    int data;
    int secs;
    bit tick;
    bit timeout;
    bit running;
  } vec_t;
  vec_t vec_q[$];

  // Behavioural model of dut_a
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_t;
  mmode_t m_mode;
  int     m_cnt;
  int     m_secs;
  bit     m_tick;

  function automatic logic [63:0] pack(int d, int s, bit t, bit to, bit r);
    logic [63:0] v;
    v        = '0;
    v[36:10] = DW'(d);
    v[9:3]   = SW'(s);
    v[2]     = t;
    v[1]     = to;
    v[0]     = r;
    return v;
  endfunction

  function automatic logic [63:0] act_a();
    return pack(int'(bus_a.data_OutBUS), int'(bus_a.seconds_OutBUS), bus_a.tick_OutHigh,
                bus_a.timeout_OutHigh, bus_a.running_OutHigh);
  endfunction

  function automatic logic [63:0] act_z();
    return pack(int'(bus_z.data_OutBUS), int'(bus_z.seconds_OutBUS), bus_z.tick_OutHigh,
                bus_z.timeout_OutHigh, bus_z.running_OutHigh);
  endfunction

  // One comparison; verbose=1 prints a line for passes too.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input bit verbose);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got data=%0d sec=%0d tick=%0b to=%0b run=%0b, want data=%0d sec=%0d tick=%0b to=%0b run=%0b",
               name, act[36:10], act[9:3], act[2], act[1], act[0],
               exp[36:10], exp[9:3], exp[2], exp[1], exp[0]);
    end else if (verbose) begin
      $display("ok   %s: data=%0d sec=%0d tick=%0b to=%0b run=%0b",
               name, act[36:10], act[9:3], act[2], act[1], act[0]);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_cnt  = 0;
    m_secs = M_INIT;
    m_tick = 0;
  endtask

  // Rules: start restarts everything; in RUN the terminal count wraps,
  // ticks and costs a second (running out ends the game) and only then
  // is a pause honoured; PAUSE waits for release; DONE sits at zero.
  task automatic model_edge(input bit st_n, input bit pa_n);
    bit at_term;
    at_term = (m_mode == M_RUN) && (m_cnt == M_TERM);
    m_tick  = 0;
    if (!st_n) begin
      m_cnt  = 0;
      m_secs = M_INIT;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (at_term) begin
        m_cnt  = 0;
        m_tick = 1;
        if (m_secs > 0) m_secs = m_secs - 1;
        if (m_secs == 0)  m_mode = M_DONE;
        else if (!pa_n)   m_mode = M_PAUSE;
      end else if (!pa_n) begin
        m_mode = M_PAUSE;
      end else begin
        m_cnt = (m_cnt + 1) % (1 << DW);
      end
    end else if (m_mode == M_PAUSE) begin
      if (pa_n) m_mode = M_RUN;
    end else if (m_mode == M_DONE) begin
      m_cnt  = 0;
      m_secs = 0;
    end
  endtask

  function automatic logic [63:0] model_out();
    return pack(m_cnt, m_secs, m_tick, m_mode == M_DONE, m_mode == M_RUN);
  endfunction

  // Called at posedge+1: drive dut_a inputs, take one edge, return at posedge+1.
  task automatic edge_a(input bit st_n, input bit pa_n);
    bus_a.start_InLow = st_n;
    bus_a.pause_InLow = pa_n;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus_a.start_InLow = 1'b1; bus_a.pause_InLow = 1'b1;
    bus_z.start_InLow = 1'b1; bus_z.pause_InLow = 1'b1;
    bus_r.start_InLow = 1'b1; bus_r.pause_InLow = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic void add(bit st_n, bit pa_n, int d, int s, bit t, bit to, bit r);
    vec_t v;
    v.start_n = st_n; v.pause_n = pa_n; v.data = d; v.secs = s;
    v.tick = t; v.timeout = to; v.running = r;
    vec_q.push_back(v);
  endfunction

  initial begin
    int prev;
    bit st_n, pa_n;

    // ---- Directed table (from reset) ----
    add(1, 1, 0, 3, 0, 0, 0);                              // IDLE holds
    add(0, 1, 0, 3, 0, 0, 1);                              // start
    for (int d = 1; d <= 4; d++) add(1, 1, d, 3, 0, 0, 1);
    for (int i = 0; i < 7; i++)  add(1, 0, 4, 3, 0, 0, 0); // pause at 4
    add(1, 1, 4, 3, 0, 0, 1);                              // released, back in RUN
    for (int d = 5; d <= 9; d++) add(1, 1, d, 3, 0, 0, 1);
    add(1, 0, 0, 2, 1, 0, 0);                              // pause with T0: wrap then PAUSE
    add(1, 0, 0, 2, 0, 0, 0);
    add(1, 1, 0, 2, 0, 0, 1);
    for (int d = 1; d <= 6; d++) add(1, 1, d, 2, 0, 0, 1);
    add(0, 1, 0, 3, 0, 0, 1);                              // restart at data 6
    for (int d = 1; d <= 9; d++) add(1, 1, d, 3, 0, 0, 1);
    add(0, 1, 0, 3, 0, 0, 1);                              // start beats T0: no tick
    add(1, 1, 1, 3, 0, 0, 1);

    do_reset();
    check("reset_a", act_a(), pack(0, 3, 0, 0, 0), 1);
    check("reset_z", act_z(), pack(0, 0, 0, 0, 0), 1);
    for (int i = 0; i < vec_q.size(); i++) begin
      edge_a(vec_q[i].start_n, vec_q[i].pause_n);
      check($sformatf("table[%0d]", i), act_a(),
            pack(vec_q[i].data, vec_q[i].secs, vec_q[i].tick, vec_q[i].timeout, vec_q[i].running), 1);
    end

    // ---- Full countdown: ticks every 10 cycles, DONE after the 3rd ----
    do_reset();
    edge_a(0, 1);
    check("count_start", act_a(), pack(0, 3, 0, 0, 1), 1);
    for (int i = 1; i <= 30; i++) begin
      edge_a(1, 1);
      check($sformatf("count[%0d]", i), act_a(),
            pack(i % 10, 3 - i / 10, (i % 10) == 0, i == 30, i < 30), 1);
    end
    for (int i = 0; i < 4; i++) begin
      edge_a(1, i[0]);
      check($sformatf("done_hold[%0d]", i), act_a(), pack(0, 0, 0, 1, 0), 1);
    end
    edge_a(0, 1);
    check("done_restart", act_a(), pack(0, 3, 0, 0, 1), 1);

    // ---- Asynchronous reset mid-run at data 5 ----
    do_reset();
    edge_a(0, 1);
    for (int i = 0; i < 5; i++) edge_a(1, 1);
    check("pre_reset", act_a(), pack(5, 3, 0, 0, 1), 1);
    #2 rst = 1'b1;
    #1;
    check("async_reset", act_a(), pack(0, 3, 0, 0, 0), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_a(1, 1);
      check($sformatf("post_reset_idle[%0d]", i), act_a(), pack(0, 3, 0, 0, 0), 1);
    end
    edge_a(0, 1);
    check("post_reset_start", act_a(), pack(0, 3, 0, 0, 1), 1);

    // ---- SECONDS_INIT = 0 build ----
    do_reset();
    bus_z.start_InLow = 1'b0;
    @(posedge clk);
    #1;
    check("zero_init_start", act_z(), pack(0, 0, 0, 1, 0), 1);
    bus_z.start_InLow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_z.pause_InLow = i[0];
      @(posedge clk);
      #1;
      check($sformatf("zero_init_hold[%0d]", i), act_z(), pack(0, 0, 0, 1, 0), 1);
    end

    // ---- Real comparator smoke: 1000 cycles, monotonic, no tick ----
    do_reset();
    bus_r.start_InLow = 1'b0;
    @(posedge clk);
    #1;
    bus_r.start_InLow = 1'b1;
    prev = int'(bus_r.data_OutBUS);
    check("real_start", pack(prev, int'(bus_r.seconds_OutBUS), bus_r.tick_OutHigh, 0, 0),
          pack(0, 60, 0, 0, 0), 1);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("real[%0d]", i),
            pack(int'(bus_r.data_OutBUS), int'(bus_r.seconds_OutBUS), bus_r.tick_OutHigh, 0, bus_r.running_OutHigh),
            pack(prev + 1, 60, 0, 0, 1), 0);
      prev = prev + 1;
    end
    $display("real comparator smoke: %0d cycles, last data=%0d", 1000, bus_r.data_OutBUS);

    // ---- Randomized run against the model ----
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      st_n = ($urandom_range(0, 99) >= 2);
      pa_n = ($urandom_range(0, 99) >= 12);
      edge_a(st_n, pa_n);
      model_edge(st_n, pa_n);
      check($sformatf("rand[%0d] st_n=%0b pa_n=%0b", i, st_n, pa_n), act_a(), model_out(), 0);
    end
    $display("random run: %0d edges", 2000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
